deflect_port_alloc: RTL and testbench

DEFLECT_PORT_ALLOC -- requirements
Module: deflect_port_alloc

---
 rtl/deflect_port_alloc.sv | 81 ++++++++
 tb/tb_deflect_port_alloc.sv | 120 ++++++++++++
 2 files changed

// File: rtl/deflect_port_alloc.sv
// deflect_port_alloc: single-cycle age-ordered deflection port allocator for a 4-slot router with local injection.
`ifndef NUM_PORT
`define NUM_PORT 5
`endif
module deflect_port_alloc #(
  parameter int AGE_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               in_valid,
  input  logic [4*`NUM_PORT-1:0]   in_ppv,
  input  logic [4*AGE_W-1:0]       in_age,
  input  logic                     inj_valid,
  input  logic [`NUM_PORT-1:0]     inj_ppv,
  output logic [4:0]               out_valid,
  output logic [5*`NUM_PORT-1:0]   out_grant,
  output logic [4:0]               out_defl,
  output logic                     inj_accept,
  output logic [CNT_W-1:0]         defl_cnt
);
  localparam int NP = `NUM_PORT;
  logic [1:0] rr_ptr;
  logic [AGE_W+1:0] key [4];
  logic [1:0] rank [4];
  logic [NP-1:0] free, pref, net;
  logic [4:0][NP-1:0] g;
  logic [4:0] n_defl;
  logic n_acc;
  logic [CNT_W:0] sum;
  function automatic logic [NP-1:0] low1(input logic [NP-1:0] x);
    return x & (-x);
  endfunction
  // Low key bits rank equal ages by round-robin distance, making every key unique.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      key[i] = {in_age[i*AGE_W +: AGE_W], ~(2'(i) - rr_ptr)};
      rank[i] = '0;
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (j != i && in_valid[j] && key[j] > key[i]) rank[i] = rank[i] + 2'd1;
  end
  always_comb begin
    free = '1;
    pref = '0;
    g = '0;
    n_defl = '0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++)
        if (in_valid[i] && rank[i] == 2'(r)) begin
          pref = in_ppv[i*NP +: NP] & free;
          g[i] = |pref ? low1(pref) : low1({1'b0, free[3:0]});
          n_defl[i] = ~|pref;
          free = free & ~g[i];
        end
    net = {1'b0, free[3:0]};
    pref = {1'b0, inj_ppv[3:0]} & net;
    n_acc = inj_valid && |net;
    g[4] = n_acc ? (|pref ? low1(pref) : low1(net)) : '0;
    n_defl[4] = n_acc && ~|pref;
    sum = {1'b0, defl_cnt} + (CNT_W+1)'($countones(n_defl));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_grant <= '0;
      out_defl <= '0;
      inj_accept <= 1'b0;
      defl_cnt <= '0;
      rr_ptr <= '0;
    end else begin
      out_valid <= {n_acc, in_valid};
      out_grant <= g;
      out_defl <= n_defl;
      inj_accept <= n_acc;
      defl_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      rr_ptr <= rr_ptr + 2'(|in_valid);
    end
  end
endmodule

// File: tb/tb_deflect_port_alloc.sv
// tb_deflect_port_alloc: directed vectors with a queued scoreboard and an independent output monitor.
module tb_deflect_port_alloc;
  logic clk = 0;
  logic rst_n;
  logic [3:0] in_valid;
  logic [19:0] in_ppv;
  logic [31:0] in_age;
  logic inj_valid;
  logic [4:0] inj_ppv;
  logic [4:0] out_valid;
  logic [24:0] out_grant;
  logic [4:0] out_defl;
  logic inj_accept;
  logic [3:0] defl_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [4:0] v;
    logic [24:0] g;
    logic [4:0] d;
    logic a;
    logic [3:0] c;
  } exp_t;
  exp_t q[$];

  deflect_port_alloc #(.AGE_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ppv(in_ppv), .in_age(in_age),
    .inj_valid(inj_valid), .inj_ppv(inj_ppv), .out_valid(out_valid), .out_grant(out_grant),
    .out_defl(out_defl), .inj_accept(inj_accept), .defl_cnt(defl_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(out_valid), 32'(e.v));
    chk({tag, ".grant"}, 32'(out_grant), 32'(e.g));
    chk({tag, ".defl"}, 32'(out_defl), 32'(e.d));
    chk({tag, ".accept"}, 32'(inj_accept), 32'(e.a));
    chk({tag, ".cnt"}, 32'(defl_cnt), 32'(e.c));
  endtask

  task automatic cyc(input logic [3:0] v, input logic [19:0] p, input logic [31:0] a,
                     input logic iv, input logic [4:0] ip, input exp_t e);
    @(negedge clk);
    in_valid = v; in_ppv = p; in_age = a; inj_valid = iv; inj_ppv = ip;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) check_all("scb", q.pop_front());
    end
  end

  initial begin
    rst_n = 1; in_valid = 0; in_ppv = 0; in_age = 0; inj_valid = 0; inj_ppv = 0;
    #3 rst_n = 0;
    #1 check_all("reset", '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    // rr=0: oldest slot1 keeps port1, others deflect in age order
    cyc(4'b1111, {4{5'b00010}}, {8'd3, 8'd1, 8'd9, 8'd5}, 0, 0,
        '{5'b01111, {5'b0, 5'b00100, 5'b01000, 5'b00010, 5'b00001}, 5'b01101, 1'b0, 4'd3});
    // rr=1, equal ages: order 1,2,3,0
    cyc(4'b1111, {4{5'b00001}}, 0, 0, 0,
        '{5'b01111, {5'b0, 5'b00100, 5'b00010, 5'b00001, 5'b01000}, 5'b01101, 1'b0, 4'd6});
    // rr=2: slot2 ejects, slot0 deflects; injection takes preferred port2
    cyc(4'b0101, {5'b0, 5'b10000, 5'b0, 5'b10000}, {8'd0, 8'd4, 8'd0, 8'd4}, 1, 5'b00100,
        '{5'b10101, {5'b00100, 5'b0, 5'b10000, 5'b0, 5'b00001}, 5'b00001, 1'b1, 4'd7});
    // rr=3: all network ports taken, injection refused
    cyc(4'b1111, {5'b01000, 5'b00100, 5'b00010, 5'b00001}, 0, 1, 5'b00001,
        '{5'b01111, {5'b0, 5'b01000, 5'b00100, 5'b00010, 5'b00001}, 5'b00000, 1'b0, 4'd7});
    // rr=0: slot3 ejects, injection deflects onto port3
    cyc(4'b1111, {5'b10000, 5'b00100, 5'b00010, 5'b00001}, 0, 1, 5'b00001,
        '{5'b11111, {5'b01000, 5'b10000, 5'b00100, 5'b00010, 5'b00001}, 5'b10000, 1'b1, 4'd8});
    repeat (2) cyc(0, 0, 0, 0, 0, '{5'b0, 25'b0, 5'b0, 1'b0, 4'd8});
    // rr held at 1 through idle: slot1 wins tie; slot3 ppv=0 deflects
    cyc(4'b1011, {5'b0, 5'b0, 5'b00100, 5'b00100}, {8'd0, 8'd0, 8'd7, 8'd7}, 0, 0,
        '{5'b01011, {5'b0, 5'b00010, 5'b0, 5'b00100, 5'b00001}, 5'b01001, 1'b0, 4'd10});
    cyc(4'b1111, 0, 0, 0, 0,
        '{5'b01111, {5'b0, 5'b00010, 5'b00001, 5'b01000, 5'b00100}, 5'b01111, 1'b0, 4'd14});
    cyc(4'b1111, 0, 0, 0, 0,
        '{5'b01111, {5'b0, 5'b00001, 5'b01000, 5'b00100, 5'b00010}, 5'b01111, 1'b0, 4'd15});
    cyc(4'b1111, 0, 0, 0, 0,
        '{5'b01111, {5'b0, 5'b01000, 5'b00100, 5'b00010, 5'b00001}, 5'b01111, 1'b0, 4'd15});
    cyc(4'b0001, {15'b0, 5'b00001}, 0, 0, 0,
        '{5'b00001, {20'b0, 5'b00001}, 5'b00000, 1'b0, 4'd15});
    @(posedge clk);
    #2 rst_n = 0;
    #1 check_all("async_rst", '0);
    @(negedge clk);
    in_valid = 4'b1111; in_ppv = 0; inj_valid = 1;
    @(posedge clk);
    #1 check_all("held_rst", '0);
    @(negedge clk);
    rst_n = 1;
    inj_valid = 0;
    // rr restarted at 0: slots deflect in index order
    q.push_back('{5'b01111, {5'b0, 5'b01000, 5'b00100, 5'b00010, 5'b00001}, 5'b01111, 1'b0, 4'd4});
    cyc(0, 0, 0, 0, 0, '{5'b0, 25'b0, 5'b0, 1'b0, 4'd4});
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
